// File: rtl/voxel_occupancy_responder_pkg.sv
// Shared voxel definitions: responder FSM states, default grid geometry and
// the coordinate -> (index, out-of-bounds) mapping, which the stepper's
// bounds logic also reuses.
package voxel_pkg;

    localparam int VOXEL_COORD_WIDTH = 16;
    localparam int VOXEL_GRID_BITS_X = 5;
    localparam int VOXEL_GRID_BITS_Y = 5;
    localparam int VOXEL_GRID_BITS_Z = 5;
    localparam int VOXEL_WORD_WIDTH  = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOOKUP  = 2'd1,
        RESPOND = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    // Linear voxel index plus out-of-bounds flag. The index is 32 bits wide
    // so the function works for any grid up to 2^32 voxels; callers slice
    // the word address and bit select out of it.
    typedef struct packed {
        logic        oob;
        logic [31:0] index;
    } voxel_loc_t;

    // Index = {z[gz-1:0], y[gy-1:0], x[gx-1:0]}. Any coordinate bit at or
    // above its grid width makes the voxel out of bounds, so a decrement
    // from 0 (wrapping to all-ones) is caught here.
    function automatic voxel_loc_t voxel_locate(
        input logic [31:0] x,
        input logic [31:0] y,
        input logic [31:0] z,
        input int          gx,
        input int          gy,
        input int          gz
    );
        voxel_loc_t  r;
        logic [31:0] mx;
        logic [31:0] my;
        logic [31:0] mz;
        mx      = (32'd1 << gx) - 32'd1;
        my      = (32'd1 << gy) - 32'd1;
        mz      = (32'd1 << gz) - 32'd1;
        r.index = ((z & mz) << (gx + gy)) | ((y & my) << gx) | (x & mx);
        r.oob   = ((x & ~mx) != 32'd0) || ((y & ~my) != 32'd0) || ((z & ~mz) != 32'd0);
        return r;
    endfunction

endpackage

// File: rtl/voxel_occupancy_responder_if.sv
// Voxel-RAM read bus between the DDA stepper (master) and the occupancy
// responder (slave). Request is level-held; response is a one-cycle strobe
// with sticky data.
interface voxel_occupancy_responder_if #(
    parameter int COORD_WIDTH = 16
);
    logic                   ram_read_req;
    logic [COORD_WIDTH-1:0] ram_addr_x;
    logic [COORD_WIDTH-1:0] ram_addr_y;
    logic [COORD_WIDTH-1:0] ram_addr_z;
    logic                   solid_valid;
    logic                   solid_bit;
    logic                   out_of_bounds;

    modport master (
        output ram_read_req, ram_addr_x, ram_addr_y, ram_addr_z,
        input  solid_valid, solid_bit, out_of_bounds
    );

    modport slave (
        input  ram_read_req, ram_addr_x, ram_addr_y, ram_addr_z,
        output solid_valid, solid_bit, out_of_bounds
    );
endinterface

// File: rtl/voxel_occupancy_responder_bitmap_ram.sv
// voxel_bitmap_ram: 1R1W synchronous word array holding the occupancy
// bitmap. Read-before-write on an address collision; no reset, so it can be
// swapped for an SRAM macro.
module voxel_bitmap_ram #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_BITS = 10
) (
    input  logic                  clock,
    input  logic                  we,
    input  logic [DEPTH_BITS-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic                  re,
    input  logic [DEPTH_BITS-1:0] raddr,
    output logic [WIDTH-1:0]      rdata
);

    logic [WIDTH-1:0] mem [2**DEPTH_BITS];

    // Both ports update with non-blocking assignments, so a same-edge read
    // of the written word returns the pre-write contents.
    always_ff @(posedge clock) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/voxel_occupancy_responder.sv
// voxel_occupancy_responder: answers the DDA stepper's voxel occupancy reads
// from an internal bitmap loaded through a word-write port.
// Optional build macro VOXEL_RESP_STATS_EN adds saturating read/hit/oob
// counters with a synchronous clear.
module voxel_occupancy_responder
    import voxel_pkg::*;
#(
    parameter int  COORD_WIDTH = VOXEL_COORD_WIDTH,
    parameter int  GRID_BITS_X = VOXEL_GRID_BITS_X,
    parameter int  GRID_BITS_Y = VOXEL_GRID_BITS_Y,
    parameter int  GRID_BITS_Z = VOXEL_GRID_BITS_Z,
    parameter int  WORD_WIDTH  = VOXEL_WORD_WIDTH,
    localparam int IW          = GRID_BITS_X + GRID_BITS_Y + GRID_BITS_Z,
    localparam int WB          = $clog2(WORD_WIDTH),
    localparam int AW          = IW - WB
) (
    input  logic                  clock,
    input  logic                  reset_n,
    voxel_occupancy_responder_if.slave rd,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_word_addr,
    input  logic [WORD_WIDTH-1:0] wr_data,
    output logic                  busy
`ifdef VOXEL_RESP_STATS_EN
    ,
    input  logic                  stat_clear,
    output logic [31:0]           stat_reads,
    output logic [31:0]           stat_hits,
    output logic [31:0]           stat_oob
`endif
);

    state_t                state;
    state_t                state_nxt;
    logic                  req_q;
    logic                  capture;
    logic                  ram_re;
    voxel_loc_t            loc;
    logic                  unused_idx_hi;
    logic [AW-1:0]         lat_word;
    logic [WB-1:0]         lat_sel;
    logic                  lat_oob;
    logic [WB-1:0]         resp_sel;
    logic                  resp_hit_en;
    logic                  resp_oob;
    logic [WORD_WIDTH-1:0] rdata;

    assign loc = voxel_locate(32'(rd.ram_addr_x), 32'(rd.ram_addr_y), 32'(rd.ram_addr_z),
                              GRID_BITS_X, GRID_BITS_Y, GRID_BITS_Z);
    assign unused_idx_hi = ^loc.index[31:IW];

    // Register the incoming request; this is the edge at which a request is
    // first seen, and DRAIN watches the same registered copy.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) req_q <= 1'b0;
        else          req_q <= rd.ram_read_req;
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next state and per-state strobes.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        ram_re    = 1'b0;
        unique case (state)
            IDLE: begin
                if (req_q) begin
                    capture   = 1'b1;
                    state_nxt = LOOKUP;
                end
            end
            LOOKUP: begin
                ram_re    = !lat_oob;
                state_nxt = RESPOND;
            end
            RESPOND: state_nxt = DRAIN;
            DRAIN:   if (!req_q) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Coordinates are only captured when leaving IDLE; address changes while
    // busy are ignored.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lat_word <= '0;
            lat_sel  <= '0;
            lat_oob  <= 1'b0;
        end else if (capture) begin
            lat_word <= loc.index[IW-1:WB];
            lat_sel  <= loc.index[WB-1:0];
            lat_oob  <= loc.oob;
        end
    end

    // Response qualifiers load on the RESPOND entry edge, together with the
    // RAM read, and hold until the next response since the initiator samples
    // the data a couple of cycles after the strobe.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            resp_sel    <= '0;
            resp_hit_en <= 1'b0;
            resp_oob    <= 1'b0;
        end else if (state == LOOKUP) begin
            resp_sel    <= lat_sel;
            resp_hit_en <= !lat_oob;
            resp_oob    <= lat_oob;
        end
    end

    voxel_bitmap_ram #(
        .WIDTH      (WORD_WIDTH),
        .DEPTH_BITS (AW)
    ) u_ram (
        .clock (clock),
        .we    (wr_en),
        .waddr (wr_word_addr),
        .wdata (wr_data),
        .re    (ram_re),
        .raddr (lat_word),
        .rdata (rdata)
    );

    // rdata only changes on a LOOKUP edge, the same edge that reloads the
    // qualifiers, so solid_bit is stable between responses. resp_hit_en
    // masks the unreset RAM output after reset and on out-of-bounds reads.
    assign rd.solid_bit     = resp_hit_en & rdata[resp_sel];
    assign rd.out_of_bounds = resp_oob;
    assign rd.solid_valid   = (state == RESPOND);
    assign busy             = (state != IDLE);

`ifdef VOXEL_RESP_STATS_EN
    // Saturating response counters; clear wins over increment.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stat_reads <= '0;
            stat_hits  <= '0;
            stat_oob   <= '0;
        end else if (stat_clear) begin
            stat_reads <= '0;
            stat_hits  <= '0;
            stat_oob   <= '0;
        end else if (state == RESPOND) begin
            if (stat_reads != '1)                 stat_reads <= stat_reads + 32'd1;
            if (rd.solid_bit && stat_hits != '1)  stat_hits  <= stat_hits + 32'd1;
            if (resp_oob && stat_oob != '1)       stat_oob   <= stat_oob + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_voxel_occupancy_responder.sv
// Self-checking bench for voxel_occupancy_responder. Expected responses are
// queued when a read is issued and compared when solid_valid fires.
// Build with VOXEL_RESP_STATS_EN defined to exercise the counters too.
module tb_voxel_occupancy_responder;

    logic        clock;
    logic        reset_n;
    logic        wr_en;
    logic [9:0]  wr_word_addr;
    logic [31:0] wr_data;
    logic        busy;
`ifdef VOXEL_RESP_STATS_EN
    logic        stat_clear;
    logic [31:0] stat_reads;
    logic [31:0] stat_hits;
    logic [31:0] stat_oob;
`endif

    int n_checks = 0;
    int n_errors = 0;
    logic [1:0] exp_q[$];   // {oob, bit}

    voxel_occupancy_responder_if #(.COORD_WIDTH(16)) bus ();

    voxel_occupancy_responder dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .rd           (bus),
        .wr_en        (wr_en),
        .wr_word_addr (wr_word_addr),
        .wr_data      (wr_data),
        .busy         (busy)
`ifdef VOXEL_RESP_STATS_EN
        ,
        .stat_clear   (stat_clear),
        .stat_reads   (stat_reads),
        .stat_hits    (stat_hits),
        .stat_oob     (stat_oob)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish (got hang, want completion)");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc1();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic write_word(input logic [9:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_word_addr = a; wr_data = d;
        cyc1();
        wr_en = 1'b0;
    endtask

    // Issue one read from a negedge and follow it to idle. Options: hold the
    // request for extra cycles, check the data stays put, write word 0 = 0
    // during LOOKUP, or drop the request during LOOKUP.
    task automatic do_read(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z,
                           input logic eb, input logic eo, input int hold,
                           input bit held_chk, input bit collide, input bit drop_early);
        int cyc;
        int extra;
        bit seen;
        logic [1:0] e;
        exp_q.push_back({eo, eb});
        bus.ram_addr_x = x; bus.ram_addr_y = y; bus.ram_addr_z = z;
        bus.ram_read_req = 1'b1;
        cyc = 0; seen = 0;
        while (!seen && cyc < 10) begin
            cyc1();
            cyc++;
            if (bus.solid_valid) seen = 1;
            if (collide && cyc == 3) wr_en = 1'b0;
            if (!seen && cyc == 2) begin
                if (collide) begin wr_en = 1'b1; wr_word_addr = '0; wr_data = '0; end
                if (drop_early) bus.ram_read_req = 1'b0;
            end
        end
        chk("latency", cyc, 3);
        if (seen && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("solid_bit", bus.solid_bit, e[0]);
            chk("out_of_bounds", bus.out_of_bounds, e[1]);
        end
        extra = 0;
        if (drop_early) begin
            cyc1();
            if (bus.solid_valid) extra++;
            chk("drain_busy", busy, 1);
            cyc1();
            chk("drain_exit", busy, 0);
        end else begin
            for (int i = 0; i < hold; i++) begin
                cyc1();
                if (bus.solid_valid) extra++;
                if (held_chk && i < 3) begin
                    chk("held_bit", bus.solid_bit, eb);
                    chk("held_oob", bus.out_of_bounds, eo);
                end
            end
            bus.ram_read_req = 1'b0;
            cyc = 0;
            while (busy && cyc < 8) begin
                cyc1();
                cyc++;
                if (bus.solid_valid) extra++;
            end
            chk("idle_after_drop", busy, 0);
        end
        chk("single_pulse", extra, 0);
    endtask

    initial begin
        int extra;
        reset_n = 1'b0;
        wr_en = 1'b0; wr_word_addr = '0; wr_data = '0;
        bus.ram_read_req = 1'b0;
        bus.ram_addr_x = '0; bus.ram_addr_y = '0; bus.ram_addr_z = '0;
`ifdef VOXEL_RESP_STATS_EN
        stat_clear = 1'b0;
`endif
        repeat (2) @(negedge clock);
        chk("rst_busy", busy, 0);
        chk("rst_valid", bus.solid_valid, 0);
        chk("rst_bit", bus.solid_bit, 0);
        chk("rst_oob", bus.out_of_bounds, 0);
        reset_n = 1'b1;
        cyc1();

        write_word(10'd0, 32'h0000_0008);
        do_read(16'd3, 16'd0, 16'd0, 1'b1, 1'b0, 5, 1'b0, 1'b0, 1'b0);
        do_read(16'd4, 16'd0, 16'd0, 1'b0, 1'b0, 4, 1'b1, 1'b0, 1'b0);
        do_read(16'hFFFF, 16'd0, 16'd0, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0);
        do_read(16'd0, 16'd32, 16'd0, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0);
        write_word(10'd1023, 32'h8000_0000);
        do_read(16'd31, 16'd31, 16'd31, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0);
        do_read(16'd3, 16'd0, 16'd0, 1'b1, 1'b0, 1, 1'b0, 1'b1, 1'b0);
        do_read(16'd3, 16'd0, 16'd0, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0);
        do_read(16'd31, 16'd31, 16'd31, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b1);
        do_read(16'd5, 16'd0, 16'd1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        do_read(16'd31, 16'd31, 16'd31, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0);

        // Reset while in LOOKUP: no response may follow.
        bus.ram_addr_x = 16'd31; bus.ram_addr_y = 16'd31; bus.ram_addr_z = 16'd31;
        bus.ram_read_req = 1'b1;
        cyc1();
        cyc1();
        chk("lookup_busy", busy, 1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_valid", bus.solid_valid, 0);
        chk("mid_rst_bit", bus.solid_bit, 0);
        chk("mid_rst_oob", bus.out_of_bounds, 0);
        bus.ram_read_req = 1'b0;
        cyc1();
        reset_n = 1'b1;
        extra = 0;
        repeat (6) begin
            cyc1();
            if (bus.solid_valid) extra++;
        end
        chk("no_valid_after_rst", extra, 0);
        chk("idle_after_rst", busy, 0);

`ifdef VOXEL_RESP_STATS_EN
        chk("stat_reads_rst", stat_reads, 0);
        chk("stat_hits_rst", stat_hits, 0);
        chk("stat_oob_rst", stat_oob, 0);
        do_read(16'd31, 16'd31, 16'd31, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0);
        do_read(16'd4, 16'd0, 16'd0, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0);
        do_read(16'hFFFF, 16'd0, 16'd0, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0);
        chk("stat_reads", stat_reads, 3);
        chk("stat_hits", stat_hits, 1);
        chk("stat_oob", stat_oob, 1);
        stat_clear = 1'b1;
        cyc1();
        stat_clear = 1'b0;
        chk("stat_reads_clr", stat_reads, 0);
        chk("stat_hits_clr", stat_hits, 0);
        chk("stat_oob_clr", stat_oob, 0);
`endif

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/voxel_occupancy_responder.md
Name: voxel_occupancy_responder

Overview:
- Responder end of the DDA stepper's voxel-RAM read interface. Holds the scene occupancy bitmap, one bit per voxel.
- Accepts level-held read requests carrying x/y/z coordinates and returns `solid_bit`, `out_of_bounds` and a one-cycle `solid_valid`.
- A separate word-write port loads the scene before traversal.

Parameters:
- COORD_WIDTH, 16, width of request coordinates
- GRID_BITS_X, 5, log2 grid extent in X
- GRID_BITS_Y, 5, log2 grid extent in Y
- GRID_BITS_Z, 5, log2 grid extent in Z
- WORD_WIDTH, 32, bitmap storage word width (power of 2)

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- ram_read_req  in  1  read request, held high by the initiator until it samples solid_valid
- ram_addr_x  in  COORD_WIDTH  voxel X
- ram_addr_y  in  COORD_WIDTH  voxel Y
- ram_addr_z  in  COORD_WIDTH  voxel Z
- solid_valid  out  1  one-cycle response strobe
- solid_bit  out  1  occupancy of the requested voxel; held until the next response
- out_of_bounds  out  1  requested voxel is outside the grid; held until the next response
- wr_en  in  1  bitmap word write enable
- wr_word_addr  in  AW  word address, where AW = GRID_BITS_X+GRID_BITS_Y+GRID_BITS_Z-$clog2(WORD_WIDTH)
- wr_data  in  WORD_WIDTH  bitmap word; bit i of word w = voxel index w*WORD_WIDTH+i
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE; solid_valid, solid_bit, out_of_bounds, busy all 0. Bitmap contents are not reset.
- Voxel index = {z[GZ-1:0], y[GY-1:0], x[GX-1:0]}.
  - Word address = index >> log2(WORD_WIDTH); bit select = index low bits.
- out-of-bounds: any coordinate bit at or above its GRID_BITS is set. A decrement from 0 wraps to 0xFFFF and is therefore out-of-bounds.
- FSM states:
  - IDLE: if ram_read_req=1, latch x/y/z, compute oob and word address, go to LOOKUP.
  - LOOKUP: synchronous read of the addressed word into a data register (skipped if oob); go to RESPOND.
  - RESPOND: solid_valid=1 for exactly this cycle. solid_bit = oob ? 0 : selected bit. out_of_bounds = oob. Go to DRAIN.
  - DRAIN: wait for ram_read_req=0, then go to IDLE. This prevents a held request from being serviced twice.
- Latency: request first sampled at edge N; solid_valid is high in the cycle after edge N+2. Fixed, no stalls.
- solid_bit and out_of_bounds are registered at the RESPOND entry edge and held until the next RESPOND, because the initiator samples them two cycles after valid.
- Request dropped during LOOKUP: the transaction still completes with a valid pulse; DRAIN then exits immediately.
- Request re-asserted in the same cycle DRAIN exits: it is serviced from IDLE on the following cycle.
- Writes:
  - Accepted in every state, committed at the edge.
  - A write to the word being read in the same LOOKUP cycle: the read returns the old data, and the write persists.
- Coordinates are captured only in IDLE. Address changes while busy are ignored.
- Reset mid-transaction aborts the read and leaves no pending valid.

Optional Feature:
- Macro: VOXEL_RESP_STATS_EN.
- Defined: adds outputs stat_reads[31:0], stat_hits[31:0] and stat_oob[31:0], plus input stat_clear.
  - Each counter increments once per RESPOND, according to the response type.
  - Counters saturate at all-ones.
  - stat_clear zeroes them synchronously and has priority over increment.
  - Counters reset to 0.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package voxel_pkg holds:
  - the state enum (IDLE/LOOKUP/RESPOND/DRAIN);
  - the default grid constants;
  - the function computing word address, bit select and oob from coordinates (reused by the stepper's bounds logic).
- One sub-module, voxel_bitmap_ram: a 1R1W synchronous word array, read-before-write, no reset. It maps to an SRAM macro for SKY130.

Test Plan:
- Write word 0 = 0x0000_0008; request (3,0,0) held until valid → solid_valid pulses in the cycle after edge N+2; solid_bit=1, out_of_bounds=0; exactly one pulse even with the request held 5 cycles.
- Request (4,0,0), same scene → solid_bit=0; value held for 3 cycles after the pulse.
- Request (0xFFFF,0,0) and (0,32,0) → out_of_bounds=1, solid_bit=0.
- Voxel (31,31,31) (index 32767, word 1023 bit 31) written to 1, request → solid_bit=1.
- In LOOKUP for (3,0,0), write word 0 = 0 → response is solid_bit=1; the next request for the same voxel returns 0.
- reset_n low during LOOKUP → no valid pulse, busy=0, all outputs 0. With VOXEL_RESP_STATS_EN defined: 3 reads (1 hit, 1 oob) → stat_reads=3, stat_hits=1, stat_oob=1; stat_clear → all 0.
